pipeline_reg_bank: RTL and testbench

PIPELINE_REG_BANK -- requirements
Module: pipeline_reg_bank

---
 rtl/mips_pkg.sv | 29 ++
 rtl/pipeline_reg_bank_serializer.sv | 76 +++++++
 rtl/pipeline_reg_bank.sv | 84 ++++++++
 tb/tb_pipeline_reg_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: stage count, stage indices, per-stage payload widths
// and the snapshot dump state encoding.
package mips_pkg;

   localparam int NUM_STAGES_DEF = 4;

   localparam int STAGE_IF_ID  = 0;
   localparam int STAGE_ID_EX  = 1;
   localparam int STAGE_EX_MEM = 2;
   localparam int STAGE_MEM_WB = 3;

   localparam int W_IF_ID  = 64;
   localparam int W_ID_EX  = 129;
   localparam int W_EX_MEM = 78;
   localparam int W_MEM_WB = 72;

   // Every stage register is sized to the widest stage payload.
   localparam int STAGE_W_MAX = W_ID_EX;

   typedef enum logic {
      SNAP_IDLE = 1'b0,
      SNAP_SEND = 1'b1
   } snap_state_t;

   function automatic int words_per_stage(input int data_w, input int word_w);
      return (data_w + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/pipeline_reg_bank_serializer.sv
// Snapshot serializer: captures all stage registers into a shadow on request and
// streams them out as a valid/ready word sequence (valid vector first).
module snapshot_serializer
   import mips_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int DATA_W     = STAGE_W_MAX,
   parameter int WORD_W     = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_snap_req,
   input  logic [NUM_STAGES*DATA_W-1:0] i_data,
   input  logic [NUM_STAGES-1:0]        i_valid,
   input  logic                         i_dump_ready,
   output logic                         o_snap_busy,
   output logic [WORD_W-1:0]            o_dump_word,
   output logic                         o_dump_valid,
   output logic                         o_dump_last
);

   localparam int WPS   = words_per_stage(DATA_W, WORD_W);
   localparam int TOTAL = 1 + NUM_STAGES * WPS;
   localparam int IDX_W = $clog2(TOTAL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

   snap_state_t                    state;
   logic [IDX_W-1:0]               idx;
   logic [TOTAL-1:0][WORD_W-1:0]   shadow;
   logic [TOTAL-1:0][WORD_W-1:0]   snap_words;

   // Each stage is zero-padded up to a whole number of words before slicing.
   always_comb begin
      logic [WPS*WORD_W-1:0] pad;
      pad = '0;
      snap_words = '0;
      snap_words[0][NUM_STAGES-1:0] = i_valid;
      for (int s = 0; s < NUM_STAGES; s++) begin
         pad = '0;
         pad[DATA_W-1:0] = i_data[s*DATA_W +: DATA_W];
         for (int w = 0; w < WPS; w++)
            snap_words[1 + s*WPS + w] = pad[w*WORD_W +: WORD_W];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= SNAP_IDLE;
         idx    <= '0;
         shadow <= '0;
      end else begin
         case (state)
            SNAP_IDLE: begin
               if (i_snap_req) begin
                  shadow <= snap_words;
                  idx    <= '0;
                  state  <= SNAP_SEND;
               end
            end
            SNAP_SEND: begin
               if (i_dump_ready) begin
                  if (idx == LAST_IDX) state <= SNAP_IDLE;
                  else                 idx   <= idx + 1'b1;
               end
            end
            default: state <= SNAP_IDLE;
         endcase
      end
   end

   assign o_snap_busy  = (state == SNAP_SEND);
   assign o_dump_valid = (state == SNAP_SEND);
   assign o_dump_last  = (state == SNAP_SEND) && (idx == LAST_IDX);
   assign o_dump_word  = shadow[idx];

endmodule

// File: rtl/pipeline_reg_bank.sv
// Bank of inter-stage pipeline registers with cascading stall, flush, bubble insertion,
// debugger step gating and a snapshot dump port.
module pipeline_reg_bank
   import mips_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int DATA_W     = STAGE_W_MAX,
   parameter int WORD_W     = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_step_en,
   input  logic [NUM_STAGES*DATA_W-1:0] i_data,
   input  logic [NUM_STAGES-1:0]        i_valid,
   input  logic [NUM_STAGES-1:0]        i_stall,
   input  logic [NUM_STAGES-1:0]        i_flush,
   output logic [NUM_STAGES*DATA_W-1:0] o_data,
   output logic [NUM_STAGES-1:0]        o_valid,
   input  logic                         i_snap_req,
   output logic                         o_snap_busy,
   output logic [WORD_W-1:0]            o_dump_word,
   output logic                         o_dump_valid,
   input  logic                         i_dump_ready,
   output logic                         o_dump_last
);

   logic [NUM_STAGES-1:0][DATA_W-1:0] stage_d, stage_q;
   logic [NUM_STAGES-1:0]             hold, bubble;

   assign stage_d = i_data;

   // A stall freezes its own register and everything upstream of it.
   always_comb begin
      hold = '0;
      for (int k = 0; k < NUM_STAGES; k++)
         hold[k] = |(i_stall >> k);
   end

   // Bubble where the upstream neighbour holds but this register does not.
   assign bubble = hold << 1;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic [DATA_W-1:0] q;
      logic              v;

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            q <= '0;
            v <= 1'b0;
         end else if (i_step_en) begin
            if (i_flush[k] || (!hold[k] && bubble[k])) begin
               q <= '0;
               v <= 1'b0;
            end else if (!hold[k]) begin
               q <= stage_d[k];
               v <= i_valid[k];
            end
         end
      end

      assign stage_q[k] = q;
      assign o_valid[k] = v;
   end

   assign o_data = stage_q;

   snapshot_serializer #(
      .NUM_STAGES (NUM_STAGES),
      .DATA_W     (DATA_W),
      .WORD_W     (WORD_W)
   ) u_snap (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_snap_req   (i_snap_req),
      .i_data       (o_data),
      .i_valid      (o_valid),
      .i_dump_ready (i_dump_ready),
      .o_snap_busy  (o_snap_busy),
      .o_dump_word  (o_dump_word),
      .o_dump_valid (o_dump_valid),
      .o_dump_last  (o_dump_last)
   );

endmodule

// File: tb/tb_pipeline_reg_bank.sv
// Directed bench for pipeline_reg_bank (4 stages x 40 bits, 32-bit dump words, 9 words)
// with scoreboard queues for register contents and dump words.
module tb_pipeline_reg_bank;

   localparam int NS = 4;
   localparam int DW = 40;
   localparam int WW = 32;

   typedef struct {
      logic [NS*DW-1:0] data;
      logic [NS-1:0]    valid;
   } pipe_exp_t;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_step_en;
   logic [NS*DW-1:0]  i_data;
   logic [NS-1:0]     i_valid, i_stall, i_flush;
   logic [NS*DW-1:0]  o_data;
   logic [NS-1:0]     o_valid;
   logic              i_snap_req, o_snap_busy, o_dump_valid, i_dump_ready, o_dump_last;
   logic [WW-1:0]     o_dump_word;

   pipe_exp_t     pipe_q[$];
   logic [WW-1:0] word_q[$];
   int            n_pass = 0;
   int            n_total = 0;

   pipeline_reg_bank #(.NUM_STAGES(NS), .DATA_W(DW), .WORD_W(WW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_step_en(i_step_en), .i_data(i_data),
      .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush), .o_data(o_data),
      .o_valid(o_valid), .i_snap_req(i_snap_req), .o_snap_busy(o_snap_busy),
      .o_dump_word(o_dump_word), .o_dump_valid(o_dump_valid),
      .i_dump_ready(i_dump_ready), .o_dump_last(o_dump_last)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [NS*DW-1:0] obs, input logic [NS*DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive one pipeline step and compare the registered result after the edge.
   task automatic pipe_step(input string tag, input logic [NS*DW-1:0] ed, input logic [NS-1:0] ev);
      pipe_exp_t e;
      pipe_q.push_back('{data: ed, valid: ev});
      tick();
      e = pipe_q.pop_front();
      check({tag, "_data"}, o_data, e.data);
      check({tag, "_valid"}, {{(NS*DW-NS){1'b0}}, o_valid}, {{(NS*DW-NS){1'b0}}, e.valid});
   endtask

   // Consume the dump, optionally toggling ready, checking words, last and stability.
   task automatic drain(input bit toggle);
      int            cyc;
      logic [WW-1:0] held, e;
      bit            have_held;
      cyc = 0;
      have_held = 0;
      while (word_q.size() > 0 && cyc < 64) begin
         i_dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         @(negedge i_clk);
         check("dump_valid", NS*DW'(o_dump_valid), NS*DW'(1));
         if (have_held) check("dump_stable", NS*DW'(o_dump_word), NS*DW'(held));
         have_held = 0;
         if (o_dump_valid && i_dump_ready) begin
            e = word_q.pop_front();
            check("dump_word", NS*DW'(o_dump_word), NS*DW'(e));
            check("dump_last", NS*DW'(o_dump_last), NS*DW'(word_q.size() == 0));
         end else begin
            held = o_dump_word;
            have_held = 1;
         end
         tick();
         cyc++;
      end
      check("dump_timeout", NS*DW'(word_q.size()), '0);
      i_dump_ready = 1'b0;
   endtask

   initial begin
      logic [NS*DW-1:0] p1, p2;
      p1 = {40'hFF_FFFF_FFFF, 40'hAB_CDEF_0123, 40'h00_0000_0001, 40'h12_3456_789A};
      p2 = {40'hC0_0000_0003, 40'hC0_0000_0002, 40'hC0_0000_0001, 40'hC0_0000_0000};

      i_rst = 1; i_step_en = 1; i_data = '0; i_valid = '0; i_stall = '0; i_flush = '0;
      i_snap_req = 0; i_dump_ready = 0;
      tick(); tick();
      check("rst_data", o_data, '0);
      check("rst_valid", NS*DW'(o_valid), '0);
      check("rst_busy", NS*DW'({o_snap_busy, o_dump_valid, o_dump_last}), '0);

      i_rst = 0;
      i_data = {40'h44, 40'h33, 40'h22, 40'h11}; i_valid = 4'b1111;
      pipe_step("load", {40'h44, 40'h33, 40'h22, 40'h11}, 4'b1111);

      i_data = {40'h88, 40'h77, 40'h66, 40'h55}; i_stall = 4'b0010;
      pipe_step("stall_bubble", {40'h88, 40'h0, 40'h22, 40'h11}, 4'b1011);

      i_flush = 4'b0010;
      pipe_step("stall_flush", {40'h88, 40'h0, 40'h0, 40'h11}, 4'b1001);

      i_stall = '0; i_flush = '0; i_data = {40'hA4, 40'hA3, 40'hA2, 40'hA1};
      pipe_step("reload", {40'hA4, 40'hA3, 40'hA2, 40'hA1}, 4'b1111);

      i_step_en = 0; i_flush = 4'b1111; i_data = {40'hB4, 40'hB3, 40'hB2, 40'hB1}; i_valid = 4'b0000;
      pipe_step("step_off", {40'hA4, 40'hA3, 40'hA2, 40'hA1}, 4'b1111);

      i_rst = 1;
      pipe_step("rst_over_step", '0, 4'b0000);

      i_rst = 0; i_step_en = 1; i_flush = '0; i_data = p1; i_valid = 4'b1111;
      pipe_step("p1_load", p1, 4'b1111);

      // Capture p1 while the pipeline moves on to p2; request stays high through the dump.
      i_data = p2; i_valid = 4'b0101; i_snap_req = 1;
      foreach (p1[i]) if (i == 0) begin
         word_q.push_back(32'h0000000F);
         word_q.push_back(32'h3456789A); word_q.push_back(32'h00000012);
         word_q.push_back(32'h00000001); word_q.push_back(32'h00000000);
         word_q.push_back(32'hCDEF0123); word_q.push_back(32'h000000AB);
         word_q.push_back(32'hFFFFFFFF); word_q.push_back(32'h000000FF);
      end
      tick();
      check("busy_after_req", NS*DW'(o_snap_busy), NS*DW'(1));
      drain(1'b1);
      i_snap_req = 0;
      check("idle_after_dump", NS*DW'({o_snap_busy, o_dump_valid, o_dump_last}), '0);
      check("pipe_during_dump", o_data, p2);
      check("valid_during_dump", NS*DW'(o_valid), NS*DW'(4'b0101));

      // Abort a dump with reset at word 4.
      i_snap_req = 1;
      tick();
      i_snap_req = 0; i_dump_ready = 1;
      repeat (4) tick();
      @(negedge i_clk);
      check("abort_word4", NS*DW'(o_dump_word), NS*DW'(32'h000000C0));
      i_rst = 1; i_dump_ready = 0;
      tick();
      check("abort_outputs", NS*DW'({o_snap_busy, o_dump_valid, o_dump_last}), '0);
      i_rst = 0;
      tick();
      i_snap_req = 1;
      word_q.push_back(32'h00000005);
      for (int s = 0; s < NS; s++) begin
         word_q.push_back(WW'(s));
         word_q.push_back(32'h000000C0);
      end
      tick();
      i_snap_req = 0;
      drain(1'b0);
      check("idle_after_restart", NS*DW'({o_snap_busy, o_dump_valid, o_dump_last}), '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
